// File: rtl/axil_bram_responder_if.sv
// AXI4-Lite bus bundle for the BRAM responder: AW/W/B write channels and AR/R read channel.
// Signal names follow the s_axi_* port names the responder exposes.
interface axil_bram_responder_if #(
    parameter int ADDR_W = 15
);
    logic [ADDR_W-1:0] s_axi_awaddr;
    logic              s_axi_awvalid;
    logic              s_axi_awready;
    logic [31:0]       s_axi_wdata;
    logic [3:0]        s_axi_wstrb;
    logic              s_axi_wvalid;
    logic              s_axi_wready;
    logic [1:0]        s_axi_bresp;
    logic              s_axi_bvalid;
    logic              s_axi_bready;
    logic [ADDR_W-1:0] s_axi_araddr;
    logic              s_axi_arvalid;
    logic              s_axi_arready;
    logic [31:0]       s_axi_rdata;
    logic [1:0]        s_axi_rresp;
    logic              s_axi_rvalid;
    logic              s_axi_rready;

    modport master (
        output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        output s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
        input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );

    modport slave (
        input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        input  s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
        output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );
endinterface

// File: rtl/axil_bram_responder.sv
// AXI4-Lite word memory with byte-strobed writes and independent read/write channels.
// Define AXIL_BRAM_SLVERR_EN to answer out-of-range word indices with SLVERR instead of wrapping.
module axil_bram_responder #(
    parameter int ADDR_W      = 15,
    parameter int DEPTH_WORDS = 8192
) (
    input  logic                   clk,
    input  logic                   reset_n,
    axil_bram_responder_if.slave   s_axi
);
    localparam int IDX_W  = ADDR_W - 2;
    localparam int MEM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [31:0] mem [DEPTH_WORDS];

    // ------------------------------------------------------------------
    // Write path: one-entry AW and W buffers, commit when both are full
    // ------------------------------------------------------------------
    logic             aw_full_q, aw_full_d;
    logic [IDX_W-1:0] aw_idx_q, aw_idx_d;
    logic             w_full_q, w_full_d;
    logic [31:0]      w_data_q, w_data_d;
    logic [3:0]       w_strb_q, w_strb_d;
    logic             awready_q, awready_d;
    logic             wready_q, wready_d;
    logic             bvalid_q, bvalid_d;
    logic [1:0]       bresp_q, bresp_d;

    logic aw_hs;
    logic w_hs;
    logic b_hs;
    logic commit;
    logic aw_oob;
    logic mem_we;

`ifdef AXIL_BRAM_SLVERR_EN
    localparam logic [31:0] DEPTH_U = 32'(DEPTH_WORDS);
    assign aw_oob = (32'(aw_idx_q) >= DEPTH_U);
`else
    assign aw_oob = 1'b0;
`endif

    assign aw_hs  = awready_q & s_axi.s_axi_awvalid;
    assign w_hs   = wready_q & s_axi.s_axi_wvalid;
    assign b_hs   = bvalid_q & s_axi.s_axi_bready;
    // A pending response blocks the next commit so bresp never changes under bvalid.
    assign commit = aw_full_q & w_full_q & ~bvalid_q;
    assign mem_we = commit & ~aw_oob;

    always_comb begin
        aw_full_d = aw_full_q;
        aw_idx_d  = aw_idx_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;

        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = aw_oob ? RESP_SLVERR : RESP_OKAY;
        end else if (b_hs) begin
            bvalid_d  = 1'b0;
        end

        // Handshakes only happen on an empty buffer, so they never overlap a commit.
        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_idx_d  = s_axi.s_axi_awaddr[ADDR_W-1:2];
        end
        if (w_hs) begin
            w_full_d  = 1'b1;
            w_data_d  = s_axi.s_axi_wdata;
            w_strb_d  = s_axi.s_axi_wstrb;
        end

        awready_d = ~aw_full_d;
        wready_d  = ~w_full_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            aw_full_q <= 1'b0;
            aw_idx_q  <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            aw_full_q <= aw_full_d;
            aw_idx_q  <= aw_idx_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    // Memory array has no reset; contents survive reset_n.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_strb_q[b]) begin
                    mem[aw_idx_q[MEM_AW-1:0]][8*b +: 8] <= w_data_q[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path: R_IDLE accepts an address, R_DATA presents and holds data
    // ------------------------------------------------------------------
    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

    rd_state_e        rd_state_q;
    logic             arready_q;
    logic             rvalid_q;
    logic [31:0]      rdata_q;
    logic [1:0]       rresp_q;
    logic [IDX_W-1:0] ar_idx_q;
    logic             ar_oob;

`ifdef AXIL_BRAM_SLVERR_EN
    assign ar_oob = (32'(ar_idx_q) >= DEPTH_U);
`else
    assign ar_oob = 1'b0;
`endif

    // The array is sampled with a non-blocking read, so a same-edge commit yields old data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_state_q <= R_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            ar_idx_q   <= '0;
        end else begin
            case (rd_state_q)
                R_IDLE: begin
                    if (arready_q && s_axi.s_axi_arvalid) begin
                        ar_idx_q   <= s_axi.s_axi_araddr[ADDR_W-1:2];
                        arready_q  <= 1'b0;
                        rd_state_q <= R_DATA;
                    end else begin
                        arready_q  <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (!rvalid_q) begin
                        rvalid_q <= 1'b1;
                        if (ar_oob) begin
                            rdata_q <= '0;
                            rresp_q <= RESP_SLVERR;
                        end else begin
                            rdata_q <= mem[ar_idx_q[MEM_AW-1:0]];
                            rresp_q <= RESP_OKAY;
                        end
                    end else if (s_axi.s_axi_rready) begin
                        rvalid_q   <= 1'b0;
                        arready_q  <= 1'b1;
                        rd_state_q <= R_IDLE;
                    end
                end
                default: begin
                    rd_state_q <= R_IDLE;
                end
            endcase
        end
    end

    assign s_axi.s_axi_awready = awready_q;
    assign s_axi.s_axi_wready  = wready_q;
    assign s_axi.s_axi_bvalid  = bvalid_q;
    assign s_axi.s_axi_bresp   = bresp_q;
    assign s_axi.s_axi_arready = arready_q;
    assign s_axi.s_axi_rvalid  = rvalid_q;
    assign s_axi.s_axi_rdata   = rdata_q;
    assign s_axi.s_axi_rresp   = rresp_q;

    // Byte-offset bits are deliberately ignored; upper index bits are ignored when wrapping.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_axi.s_axi_awaddr[1:0], s_axi.s_axi_araddr[1:0], aw_idx_q, ar_idx_q};

endmodule

// File: tb/tb_axil_bram_responder.sv
// Directed self-checking bench for axil_bram_responder: a full-size instance plus a 16-word
// instance for the out-of-range cases, both driven through one muxed set of bench signals.
module tb_axil_bram_responder;
    logic clk = 1'b0;
    logic reset_n;
    logic sel_small;

    always #5 clk = ~clk;

    logic [14:0] awaddr, araddr;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef AXIL_BRAM_SLVERR_EN
    localparam logic [1:0]  EXP_OOB_RESP = 2'b10;
    localparam logic [31:0] EXP_OOB_RD   = 32'h0000_0000;
    localparam logic [31:0] EXP_WORD0    = 32'h0BAD_F00D;
`else
    localparam logic [1:0]  EXP_OOB_RESP = 2'b00;
    localparam logic [31:0] EXP_OOB_RD   = 32'h1357_9BDF;
    localparam logic [31:0] EXP_WORD0    = 32'h1357_9BDF;
`endif

    axil_bram_responder_if #(.ADDR_W(15)) bus ();
    axil_bram_responder_if #(.ADDR_W(15)) sbus ();

    assign bus.s_axi_awaddr   = awaddr;
    assign bus.s_axi_awvalid  = awvalid & ~sel_small;
    assign bus.s_axi_wdata    = wdata;
    assign bus.s_axi_wstrb    = wstrb;
    assign bus.s_axi_wvalid   = wvalid & ~sel_small;
    assign bus.s_axi_bready   = bready & ~sel_small;
    assign bus.s_axi_araddr   = araddr;
    assign bus.s_axi_arvalid  = arvalid & ~sel_small;
    assign bus.s_axi_rready   = rready & ~sel_small;

    assign sbus.s_axi_awaddr  = awaddr;
    assign sbus.s_axi_awvalid = awvalid & sel_small;
    assign sbus.s_axi_wdata   = wdata;
    assign sbus.s_axi_wstrb   = wstrb;
    assign sbus.s_axi_wvalid  = wvalid & sel_small;
    assign sbus.s_axi_bready  = bready & sel_small;
    assign sbus.s_axi_araddr  = araddr;
    assign sbus.s_axi_arvalid = arvalid & sel_small;
    assign sbus.s_axi_rready  = rready & sel_small;

    assign awready = sel_small ? sbus.s_axi_awready : bus.s_axi_awready;
    assign wready  = sel_small ? sbus.s_axi_wready  : bus.s_axi_wready;
    assign bvalid  = sel_small ? sbus.s_axi_bvalid  : bus.s_axi_bvalid;
    assign bresp   = sel_small ? sbus.s_axi_bresp   : bus.s_axi_bresp;
    assign arready = sel_small ? sbus.s_axi_arready : bus.s_axi_arready;
    assign rvalid  = sel_small ? sbus.s_axi_rvalid  : bus.s_axi_rvalid;
    assign rdata   = sel_small ? sbus.s_axi_rdata   : bus.s_axi_rdata;
    assign rresp   = sel_small ? sbus.s_axi_rresp   : bus.s_axi_rresp;

    axil_bram_responder #(.ADDR_W(15), .DEPTH_WORDS(8192)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .s_axi   (bus.slave)
    );

    axil_bram_responder #(.ADDR_W(15), .DEPTH_WORDS(16)) dut_small (
        .clk     (clk),
        .reset_n (reset_n),
        .s_axi   (sbus.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [14:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        bit   aw_done = 1'b0;
        bit   w_done  = 1'b0;
        bit   got_b   = 1'b0;
        logic aw_hs, w_hs;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        for (int i = 0; i < 20 && !(aw_done && w_done); i++) begin
            aw_hs = awvalid & awready;
            w_hs  = wvalid & wready;
            tick();
            if (aw_hs) begin awvalid = 1'b0; aw_done = 1'b1; end
            if (w_hs)  begin wvalid  = 1'b0; w_done  = 1'b1; end
        end
        if (!(aw_done && w_done)) begin
            n_fail++;
            $display("FAIL write_handshake_timeout addr=%h got aw=%0b w=%0b required both 1", a, aw_done, w_done);
            awvalid = 1'b0; wvalid = 1'b0;
        end
        resp = 2'bxx;
        for (int i = 0; i < 20 && !got_b; i++) begin
            if (bvalid) begin resp = bresp; got_b = 1'b1; end
            tick();
        end
        if (!got_b) begin
            n_fail++;
            $display("FAIL write_bresp_timeout addr=%h got bvalid=0 required 1", a);
        end
        bready = 1'b0;
        $display("write addr=%h data=%h strb=%h resp=%b", a, d, s, resp);
    endtask

    task automatic axi_read(input logic [14:0] a, output logic [31:0] d, output logic [1:0] resp);
        bit   ar_done = 1'b0;
        bit   got_r   = 1'b0;
        logic ar_hs;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        for (int i = 0; i < 20 && !ar_done; i++) begin
            ar_hs = arvalid & arready;
            tick();
            if (ar_hs) begin arvalid = 1'b0; ar_done = 1'b1; end
        end
        if (!ar_done) begin
            n_fail++;
            $display("FAIL read_ar_timeout addr=%h got arready=0 required 1", a);
            arvalid = 1'b0;
        end
        d = 32'hxxxx_xxxx; resp = 2'bxx;
        for (int i = 0; i < 20 && !got_r; i++) begin
            if (rvalid) begin d = rdata; resp = rresp; got_r = 1'b1; end
            tick();
        end
        if (!got_r) begin
            n_fail++;
            $display("FAIL read_r_timeout addr=%h got rvalid=0 required 1", a);
        end
        rready = 1'b0;
        $display("read  addr=%h data=%h resp=%b", a, d, resp);
    endtask

    task automatic test_reset();
        logic [40:0] obs;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        obs = {awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp};
        n_checks++;
        if (obs !== 41'h0) begin
            n_fail++; $display("FAIL reset_outputs got %h required 0", obs);
        end
        tick(); tick();
        obs = {awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp};
        n_checks++;
        if (obs !== 41'h0) begin
            n_fail++; $display("FAIL reset_outputs_held got %h required 0", obs);
        end
        reset_n = 1'b1;
        #1;
        n_checks++;
        if ({awready, wready, arready} !== 3'b000) begin
            n_fail++; $display("FAIL readies_before_edge got %b required 000", {awready, wready, arready});
        end
        tick();
        n_checks++;
        if ({awready, wready, arready} !== 3'b111) begin
            n_fail++; $display("FAIL readies_after_release got %b required 111", {awready, wready, arready});
        end
        $display("reset released, readies=%b", {awready, wready, arready});
    endtask

    task automatic test_write_read();
        awaddr = 15'h0004; wdata = 32'h0064_0032; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        n_checks++;
        if ({bvalid, awready, wready} !== 3'b000) begin
            n_fail++; $display("FAIL wr_edge_k bvalid/awready/wready got %b required 000", {bvalid, awready, wready});
        end
        tick();
        n_checks++;
        if ({bvalid, bresp, awready, wready} !== 5'b1_00_11) begin
            n_fail++; $display("FAIL wr_edge_k1 bvalid/bresp/awready/wready got %b required 10011", {bvalid, bresp, awready, wready});
        end
        tick();
        bready = 1'b0;
        n_checks++;
        if (bvalid !== 1'b0) begin
            n_fail++; $display("FAIL wr_edge_k2 bvalid got %b required 0", bvalid);
        end
        $display("write addr=0004 data=00640032 done");

        araddr = 15'h0004; arvalid = 1'b1; rready = 1'b1;
        tick();
        arvalid = 1'b0;
        n_checks++;
        if ({arready, rvalid} !== 2'b00) begin
            n_fail++; $display("FAIL rd_edge_k arready/rvalid got %b required 00", {arready, rvalid});
        end
        tick();
        n_checks++;
        if ({rvalid, rresp, rdata} !== {1'b1, 2'b00, 32'h0064_0032}) begin
            n_fail++; $display("FAIL rd_edge_k1 rvalid/rresp/rdata got %b/%b/%h required 1/00/00640032", rvalid, rresp, rdata);
        end
        tick();
        rready = 1'b0;
        n_checks++;
        if ({rvalid, arready} !== 2'b01) begin
            n_fail++; $display("FAIL rd_edge_k2 rvalid/arready got %b required 01", {rvalid, arready});
        end
        $display("read  addr=0004 data=%h done", rdata);
    endtask

    task automatic test_strobe_split();
        logic [1:0]  r;
        logic [31:0] d;
        axi_write(15'h1FF0, 32'hAABB_CCDD, 4'hF, r);
        awaddr = 15'h1FF0; awvalid = 1'b1; bready = 1'b1;
        tick();
        awvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({awready, wready, bvalid} !== 3'b010) begin
                n_fail++; $display("FAIL split_aw_alone cycle %0d awready/wready/bvalid got %b required 010", i, {awready, wready, bvalid});
            end
            if (i < 2) tick();
        end
        wdata = 32'h1122_3344; wstrb = 4'b0101; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        tick();
        n_checks++;
        if ({bvalid, bresp} !== 3'b1_00) begin
            n_fail++; $display("FAIL split_bresp got %b required 100", {bvalid, bresp});
        end
        tick();
        bready = 1'b0;
        axi_read(15'h1FF3, d, r);
        n_checks++;
        if ({d, r} !== {32'hAA22_CC44, 2'b00}) begin
            n_fail++; $display("FAIL strobe_merge got %h/%b required aa22cc44/00", d, r);
        end
    endtask

    task automatic test_backpressure();
        logic [1:0]  r;
        logic [31:0] d;
        axi_write(15'h0014, 32'hDEAD_0001, 4'hF, r);
        awaddr = 15'h0010; wdata = 32'h1234_5678; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0; rready = 1'b0;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        n_checks++;
        if ({bvalid, bresp} !== 3'b1_00) begin
            n_fail++; $display("FAIL bp_first_b got %b required 100", {bvalid, bresp});
        end
        awaddr = 15'h0014; wdata = 32'hCAFE_F00D; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 15'h0014; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if ({bvalid, bresp, awready, wready} !== 5'b1_00_00) begin
                n_fail++; $display("FAIL bp_b_hold cycle %0d bvalid/bresp/awready/wready got %b required 10000", i, {bvalid, bresp, awready, wready});
            end
            n_checks++;
            if ({rvalid, rresp, rdata} !== {1'b1, 2'b00, 32'hDEAD_0001}) begin
                n_fail++; $display("FAIL bp_r_hold cycle %0d got %b/%b/%h required 1/00/dead0001", i, rvalid, rresp, rdata);
            end
        end
        bready = 1'b1; rready = 1'b1;
        tick();
        n_checks++;
        if ({bvalid, rvalid} !== 2'b00) begin
            n_fail++; $display("FAIL bp_handshake bvalid/rvalid got %b required 00", {bvalid, rvalid});
        end
        rready = 1'b0;
        tick();
        n_checks++;
        if ({bvalid, bresp, awready} !== 4'b1_00_1) begin
            n_fail++; $display("FAIL bp_second_commit bvalid/bresp/awready got %b required 1001", {bvalid, bresp, awready});
        end
        tick();
        bready = 1'b0;
        axi_read(15'h0014, d, r);
        n_checks++;
        if (d !== 32'hCAFE_F00D) begin
            n_fail++; $display("FAIL bp_second_data got %h required cafef00d", d);
        end
        axi_read(15'h0010, d, r);
        n_checks++;
        if (d !== 32'h1234_5678) begin
            n_fail++; $display("FAIL bp_first_data got %h required 12345678", d);
        end
    endtask

    task automatic test_collision();
        logic [1:0]  r;
        logic [31:0] d;
        axi_write(15'h0008, 32'h0000_0005, 4'hF, r);
        awaddr = 15'h0008; wdata = 32'h0000_0009; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        araddr = 15'h0008; arvalid = 1'b1; rready = 1'b0;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        tick();
        n_checks++;
        if ({rvalid, bvalid, rdata} !== {1'b1, 1'b1, 32'h0000_0005}) begin
            n_fail++; $display("FAIL collision_read_first rvalid/bvalid/rdata got %b/%b/%h required 1/1/00000005", rvalid, bvalid, rdata);
        end
        rready = 1'b1;
        tick();
        rready = 1'b0; bready = 1'b0;
        axi_read(15'h0008, d, r);
        n_checks++;
        if (d !== 32'h0000_0009) begin
            n_fail++; $display("FAIL collision_after got %h required 00000009", d);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [1:0]  r;
        logic [31:0] d;
        logic [40:0] obs;
        axi_write(15'h0020, 32'h1111_1111, 4'hF, r);
        awaddr = 15'h0020; wdata = 32'h2222_2222; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        obs = {awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp};
        n_checks++;
        if (obs !== 41'h0) begin
            n_fail++; $display("FAIL midreset_outputs got %h required 0", obs);
        end
        tick();
        reset_n = 1'b1;
        bready = 1'b0;
        n_checks++;
        if ({awready, wready, arready, bvalid} !== 4'b0000) begin
            n_fail++; $display("FAIL midreset_before_edge got %b required 0000", {awready, wready, arready, bvalid});
        end
        tick();
        n_checks++;
        if ({awready, wready, arready, bvalid} !== 4'b1110) begin
            n_fail++; $display("FAIL midreset_after_release got %b required 1110", {awready, wready, arready, bvalid});
        end
        axi_read(15'h0020, d, r);
        n_checks++;
        if (d !== 32'h1111_1111) begin
            n_fail++; $display("FAIL midreset_no_commit got %h required 11111111", d);
        end
    endtask

    task automatic test_out_of_range();
        logic [1:0]  r;
        logic [31:0] d;
        sel_small = 1'b1;
        #1;
        axi_write(15'h0000, 32'h0BAD_F00D, 4'hF, r);
        n_checks++;
        if (r !== 2'b00) begin
            n_fail++; $display("FAIL oob_preload_resp got %b required 00", r);
        end
        axi_write(15'h0040, 32'h1357_9BDF, 4'hF, r);
        n_checks++;
        if (r !== EXP_OOB_RESP) begin
            n_fail++; $display("FAIL oob_bresp got %b required %b", r, EXP_OOB_RESP);
        end
        axi_read(15'h0040, d, r);
        n_checks++;
        if ({d, r} !== {EXP_OOB_RD, EXP_OOB_RESP}) begin
            n_fail++; $display("FAIL oob_read got %h/%b required %h/%b", d, r, EXP_OOB_RD, EXP_OOB_RESP);
        end
        axi_read(15'h0000, d, r);
        n_checks++;
        if ({d, r} !== {EXP_WORD0, 2'b00}) begin
            n_fail++; $display("FAIL oob_word0 got %h/%b required %h/00", d, r, EXP_WORD0);
        end
        sel_small = 1'b0;
    endtask

    initial begin
        sel_small = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        test_reset();
        test_write_read();
        test_strobe_split();
        test_backpressure();
        test_collision();
        test_reset_mid_write();
        test_out_of_range();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
